baccarat_datapath: RTL
======================

Name: baccarat_datapath

Overview:
- Card-holding datapath for the baccarat hand; the consumer end of the load/score interface.
- Receives the six one-cycle load strobes from the hand state machine and captures dealt cards into six card registers.
- Returns player score, dealer score and player third card to the state machine.
- Exposes raw card registers for the display logic. An internal deal counter is the card source.

Parameters:
- CARD_SEED, 1, deal counter value after reset. Legal range 1..13; an out-of-range value is a synthesis error.

Ports:
- slow_clock  input  1  system clock; all state updates on its rising edge
- resetb  input  1  asynchronous, active-low reset
- load_pcard1  input  1  capture current card into player card 1
- load_pcard2  input  1  capture current card into player card 2
- load_pcard3  input  1  capture current card into player card 3
- load_dcard1  input  1  capture current card into dealer card 1
- load_dcard2  input  1  capture current card into dealer card 2
- load_dcard3  input  1  capture current card into dealer card 3
- pcard1_out..pcard3_out  output  4 each  player card registers; 0 = empty, 1 = A .. 13 = K
- dcard1_out..dcard3_out  output  4 each  dealer card registers; same encoding
- pscore  output  4  player hand score, 0..9
- dscore  output  4  dealer hand score, 0..9
- pcard3  output  4  baccarat value of player card 3, 0..9; 0 when empty

Behaviour:
- Reset (resetb low, asynchronous):
  - all six card registers = 0; pscore = dscore = pcard3 = 0
  - deal counter = CARD_SEED
  - Reset asserted mid-hand clears everything immediately, with no clock required.
- Deal counter (sub-module dealcard):
  - advances every rising edge: 1→2→…→13→1
  - never holds 0
  - runs whether or not any load is asserted
- Load:
  - at a rising edge with load_Xcardn = 1, register Xcardn takes the counter value present before that edge.
  - The counter also advances on the same edge.
  - Latency: the card register updates on the edge where the load is sampled.
  - Scores follow combinationally from the registers, so they are valid in the same cycle the register changes.
- Multiple loads in one cycle: every asserted register captures the same counter value. No priority and no error flag.
- Reloading a non-empty register overwrites it. Unasserted registers hold their value.
- Card value: 1..9 → 1..9; 10, 11, 12, 13 → 0; 0 (empty) → 0. Values 14, 15 are unreachable; map them to 0.
- Score arithmetic:
  - score = (v1 + v2 + v3) mod 10
  - the sum uses a 5-bit intermediate (max 27) and is reduced by conditional subtraction of 10 or 20; no divider.
- pcard3 = value(player card 3), independent of pscore.
- No clock enable and no hand-done output. Sequencing is entirely the state machine's responsibility.

Decomposition:
- Shared package contents:
  - card encoding constants (CARD_EMPTY = 0, CARD_ACE = 1, CARD_KING = 13)
  - 4-bit card typedef
  - function card_value(card) → 0..9
  - function hand_score(c1, c2, c3) → 0..9
- Sub-module dealcard: ports slow_clock, resetb, new_card[3:0], with CARD_SEED passed through.
- Top level instantiates one dealcard, six register blocks and two score instances. The statemachine module connects its load outputs and score inputs to this block.

Test Plan:
- Reset check: assert resetb low mid-cycle → all card outputs, pscore, dscore, pcard3 = 0 immediately. Release, then take 13 clocks with no loads → counter returns to CARD_SEED (observe by loading pcard1 on edge 14 and expecting 1 with default seed).
- Basic deal, CARD_SEED = 1:
  - load_pcard1 on edge 1 → pcard1_out = 1
  - load_dcard1 on edge 2 → dcard1_out = 2
  - load_pcard2 on edge 3 → pcard2_out = 3; pscore = 4, dscore = 2
- Face cards and mod 10:
  - player cards 9, 8, 13 → pscore = 7, pcard3 = 0
  - dealer cards 10, 11, 12 → dscore = 0
- Wrap: counter at 13, load_dcard3 → dcard3_out = 13. Next-edge load_pcard3 → pcard3_out = 1, pcard3 = 1.
- Simultaneous loads: all six loads high on one edge with counter = 7 → all registers = 7, pscore = dscore = 1.
- Overwrite and reset mid-hand: load_pcard1 twice at counter values 5 then 6 → pcard1_out = 6. Pulse resetb low between edges → all outputs 0 without a clock edge.

Source files
------------

// File: rtl/baccarat_datapath_pkg.sv
// Shared card encoding and baccarat scoring helpers for the hand datapath.
// Cards are 4-bit ranks (0 = empty, 1 = ace .. 13 = king).
package baccarat_datapath_pkg;

  typedef logic [3:0] card_t;

  localparam card_t CARD_EMPTY = 4'd0;
  localparam card_t CARD_ACE   = 4'd1;
  localparam card_t CARD_NINE  = 4'd9;
  localparam card_t CARD_KING  = 4'd13;

  // Tens, faces, empty slots and the unreachable codes 14/15 all count as zero.
  function automatic logic [3:0] card_value(input card_t c);
    return (c >= CARD_ACE && c <= CARD_NINE) ? c : 4'd0;
  endfunction

  // Sum of three values is at most 27, so one conditional subtraction of 10 or 20 gives mod 10.
  function automatic logic [3:0] hand_score(input card_t c1, input card_t c2, input card_t c3);
    logic [4:0] sum;
    logic [4:0] red;
    sum = {1'b0, card_value(c1)} + {1'b0, card_value(c2)} + {1'b0, card_value(c3)};
    if (sum >= 5'd20)
      red = sum - 5'd20;
    else if (sum >= 5'd10)
      red = sum - 5'd10;
    else
      red = sum;
    return red[3:0];
  endfunction

endpackage

// File: rtl/baccarat_datapath_dealcard.sv
// Free-running card source: cycles 1..13 every clock, restarting at CARD_SEED on reset.
module dealcard
  import baccarat_datapath_pkg::*;
#(
  parameter int CARD_SEED = 1
) (
  input  logic       slow_clock,
  input  logic       resetb,
  output logic [3:0] new_card
);

  if (CARD_SEED < 1 || CARD_SEED > 13) begin : g_bad_seed
    $error("dealcard: CARD_SEED must be in 1..13");
  end

  localparam card_t SEED = CARD_SEED[3:0];

  card_t count_q;
  card_t count_d;

  always_comb begin
    count_d = count_q + 4'd1;
    if (count_q == CARD_KING)
      count_d = CARD_ACE;
  end

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb)
      count_q <= SEED;
    else
      count_q <= count_d;
  end

  assign new_card = count_q;

endmodule

// File: rtl/baccarat_datapath.sv
// Baccarat hand datapath: six card registers loaded from the deal counter,
// with combinational player/dealer scores and the player third-card value.
module baccarat_datapath
  import baccarat_datapath_pkg::*;
#(
  parameter int CARD_SEED = 1
) (
  input  logic       slow_clock,
  input  logic       resetb,
  input  logic       load_pcard1,
  input  logic       load_pcard2,
  input  logic       load_pcard3,
  input  logic       load_dcard1,
  input  logic       load_dcard2,
  input  logic       load_dcard3,
  output logic [3:0] pcard1_out,
  output logic [3:0] pcard2_out,
  output logic [3:0] pcard3_out,
  output logic [3:0] dcard1_out,
  output logic [3:0] dcard2_out,
  output logic [3:0] dcard3_out,
  output logic [3:0] pscore,
  output logic [3:0] dscore,
  output logic [3:0] pcard3
);

  card_t      new_card;
  logic [5:0] load;
  card_t      card [6];

  dealcard #(
    .CARD_SEED (CARD_SEED)
  ) u_dealcard (
    .slow_clock (slow_clock),
    .resetb     (resetb),
    .new_card   (new_card)
  );

  // Slots 0..2 are player cards 1..3, slots 3..5 dealer cards 1..3.
  assign load = {load_dcard3, load_dcard2, load_dcard1, load_pcard3, load_pcard2, load_pcard1};

  genvar gi;
  for (gi = 0; gi < 6; gi++) begin : g_card_reg
    card_t card_q;
    card_t card_d;

    always_comb begin
      card_d = card_q;
      if (load[gi])
        card_d = new_card;
    end

    always_ff @(posedge slow_clock or negedge resetb) begin
      if (!resetb)
        card_q <= CARD_EMPTY;
      else
        card_q <= card_d;
    end

    assign card[gi] = card_q;
  end

  assign pcard1_out = card[0];
  assign pcard2_out = card[1];
  assign pcard3_out = card[2];
  assign dcard1_out = card[3];
  assign dcard2_out = card[4];
  assign dcard3_out = card[5];

  assign pscore = hand_score(card[0], card[1], card[2]);
  assign dscore = hand_score(card[3], card[4], card[5]);
  assign pcard3 = card_value(card[2]);

endmodule
